// File: rtl/frecuenciometro_pkg.sv
// frecuenciometro_pkg: shared defaults and FSM states for the frequency meter
package frecuenciometro_pkg;
  localparam int CLK_HZ_DEF = 50_000_000;
  localparam int N_DEF = 17;
  typedef enum logic [1:0] {IDLE, CONTANDO, CAPTURA} estado_t;
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: two-flop synchronizer followed by a rising-edge detector
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic flanco
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[1:0], d};
  assign flanco = s[1] & ~s[2];
endmodule

// File: rtl/medidor_frecuencia.sv
// medidor_frecuencia: counts synchronized rising edges of senal_in per gate window
module medidor_frecuencia
  import frecuenciometro_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int CLK_HZ = CLK_HZ_DEF,
  parameter int GATE_CYCLES = CLK_HZ
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         senal_in,
  input  logic         habilitar,
  output logic [N-1:0] bin,
  output logic         valido,
  output logic         desborde
);
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] ULTIMO = TW'(GATE_CYCLES - 1);
  estado_t estado;
  logic [TW-1:0] timer;
  logic [N-1:0] cnt;
  logic sat, flanco;
  detector_flanco u_det (.clk(clk), .rst_n(rst_n), .d(senal_in), .flanco(flanco));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      estado   <= IDLE;
      timer    <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      bin      <= '0;
      valido   <= 1'b0;
      desborde <= 1'b0;
    end else begin
      valido <= 1'b0;
      case (estado)
        IDLE: begin
          timer <= '0;
          cnt   <= '0;
          sat   <= 1'b0;
          if (habilitar) estado <= CONTANDO;
        end
        CONTANDO:
          if (!habilitar) begin
            estado <= IDLE;
            timer  <= '0;
            cnt    <= '0;
            sat    <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
            // a saturated counter keeps its value and only raises the overflow flag
            if (flanco) begin
              if (&cnt) sat <= 1'b1;
              else cnt <= cnt + 1'b1;
            end
            if (timer == ULTIMO) estado <= CAPTURA;
          end
        CAPTURA: begin
          bin      <= cnt;
          desborde <= sat;
          valido   <= 1'b1;
          timer    <= '0;
          cnt      <= '0;
          sat      <= 1'b0;
          estado   <= habilitar ? CONTANDO : IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_medidor_frecuencia.sv
// tb_medidor_frecuencia: window-level model checked every cycle plus directed literal checks
module tb_medidor_frecuencia;
  localparam int G = 100;
  logic clk = 0, rst_n = 0, senal_in = 0, habilitar = 0;
  logic [7:0] bin8;
  logic [4:0] bin5;
  logic val8, val5, des8, des5;
  int tests = 0, fails = 0, nval = 0;
  int per = 0, ph = 0;
  logic lvl = 0;
  always #5 clk = ~clk;
  medidor_frecuencia #(.N(8), .CLK_HZ(1000), .GATE_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .senal_in(senal_in), .habilitar(habilitar),
    .bin(bin8), .valido(val8), .desborde(des8));
  medidor_frecuencia #(.N(5), .CLK_HZ(1000), .GATE_CYCLES(G)) dut5 (
    .clk(clk), .rst_n(rst_n), .senal_in(senal_in), .habilitar(habilitar),
    .bin(bin5), .valido(val5), .desborde(des5));
  // stimulus source: fixed level when per==0, otherwise a square wave of period per
  initial forever begin
    @(posedge clk);
    #2;
    ph = ph + 1;
    senal_in = (per == 0) ? lvl : ((ph % per) < per / 2);
  end
  // model: a rise sampled at edge k is counted at edge k+2; window = G counting edges then a capture edge
  logic h1 = 0, h2 = 0, h3 = 0, m_open = 0, ev;
  int m_t = 0, raw = 0, e_bin8 = 0, e_bin5 = 0;
  logic e_val = 0, e_des8 = 0, e_des5 = 0;
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      {h1, h2, h3, m_open, e_val, e_des8, e_des5} = '0;
      e_bin8 = 0;
      e_bin5 = 0;
    end else begin
      ev = h2 && !h3;
      h3 = h2;
      h2 = h1;
      h1 = senal_in;
      e_val = 0;
      if (!m_open) begin
        if (habilitar) begin m_open = 1; m_t = 0; raw = 0; end
      end else begin
        m_t++;
        if (m_t <= G) begin
          if (!habilitar) m_open = 0;
          else raw += int'(ev);
        end else begin
          e_val = 1;
          e_bin8 = raw > 255 ? 255 : raw;
          e_des8 = raw > 255;
          e_bin5 = raw > 31 ? 31 : raw;
          e_des5 = raw > 31;
          if (habilitar) begin m_t = 0; raw = 0; end
          else m_open = 0;
        end
      end
    end
  end
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (val8) nval++;
    check("bin8", int'(bin8), rst_n ? e_bin8 : 0);
    check("val8", int'(val8), rst_n ? int'(e_val) : 0);
    check("des8", int'(des8), rst_n ? int'(e_des8) : 0);
    check("bin5", int'(bin5), rst_n ? e_bin5 : 0);
    check("val5", int'(val5), rst_n ? int'(e_val) : 0);
    check("des5", int'(des5), rst_n ? int'(e_des5) : 0);
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_v(output int k);
    k = 0;
    do begin tick(1); k++; end while (!val8 && k < 300);
    if (!val8) begin
      fails++;
      $display("FAIL valido_timeout: got no pulse in %0d cycles, expected one", k);
    end
  endtask
  int k, b, w1, w2, nv0;
  initial begin
    tick(3);
    check("rst_bin", int'(bin8), 0);
    check("rst_val", int'(val8), 0);
    check("rst_des", int'(des8), 0);
    rst_n = 1;
    per = 10;
    habilitar = 1;
    wait_v(k);
    check("first_lat", k, 102);
    wait_v(k);
    check_rng("p10_bin", int'(bin8), 9, 10);
    check("p10_des", int'(des8), 0);
    per = 2;
    wait_v(k);
    wait_v(k);
    check_rng("p2_bin", int'(bin8), 49, 50);
    check("p2_des", int'(des8), 0);
    check("p2_bin5", int'(bin5), 31);
    check("p2_des5", int'(des5), 1);
    per = 0;
    lvl = 0;
    wait_v(k);
    wait_v(k);
    check("low_bin", int'(bin8), 0);
    lvl = 1;
    wait_v(k);
    w1 = int'(bin8);
    wait_v(k);
    w2 = int'(bin8);
    check_rng("high_edges", w1 + w2, 0, 1);
    wait_v(k);
    check("high_bin", int'(bin8), 0);
    per = 10;
    wait_v(k);
    wait_v(k);
    b = int'(bin8);
    check("pre_abort_bin", b, 10);
    tick(50);
    habilitar = 0;
    nv0 = nval;
    tick(150);
    check("abort_noval", nval - nv0, 0);
    check("abort_bin", int'(bin8), 10);
    habilitar = 1;
    wait_v(k);
    check("reen_lat", k, 102);
    tick(70);
    rst_n = 0;
    tick(1);
    check("mid_rst_bin", int'(bin8), 0);
    check("mid_rst_val", int'(val8), 0);
    check("mid_rst_des", int'(des8), 0);
    tick(1);
    rst_n = 1;
    wait_v(k);
    check("rst_lat", k, 102);
    check_rng("rst_bin_after", int'(bin8), 9, 10);
    habilitar = 0;
    per = 0;
    lvl = 0;
    tick(5);
    habilitar = 1;
    tick(98);
    lvl = 1;
    tick(2);
    lvl = 0;
    wait_v(k);
    check("last_cyc_lat", k, 2);
    check("last_cyc_bin", int'(bin8), 1);
    tick(98);
    lvl = 1;
    tick(2);
    lvl = 0;
    wait_v(k);
    check("capt_lat", k, 1);
    check("capt_bin", int'(bin8), 0);
    wait_v(k);
    check("capt_next_bin", int'(bin8), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
